// File: rtl/gaussian_pkg.sv
// Shared constants and types for the streaming 3x3 Gaussian blur stage.
// Rounding mode is chosen in gaussian_blur by the GAUSSIAN_ROUND_EN macro.
package gaussian_pkg;

  localparam int DEF_WIDTH  = 720;
  localparam int DEF_HEIGHT = 540;

  // Kernel [1 2 1; 2 4 2; 1 2 1], normalised by 16.
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;

  localparam int SUM_SHIFT   = 4;
  localparam int ROUND_CONST = 8;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/gaussian_window.sv
// Two-line-plus-three-pixel window shift register for the 3x3 blur.
// Exposes the nine neighbourhood taps; taps[4] is the centre pixel.
module gaussian_window
  import gaussian_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       shift_en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [8:0][DATA_WIDTH-1:0] taps
);

  localparam int LEN = 2 * WIDTH + 3;

  logic [DATA_WIDTH-1:0] sr_r [LEN];

  // Window shift: sr_r[0] receives the newest pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++) sr_r[i] <= '0;
    end else if (shift_en) begin
      sr_r[0] <= din;
      for (int i = 1; i < LEN; i++) sr_r[i] <= sr_r[i-1];
    end
  end

  assign taps[0] = sr_r[0];
  assign taps[1] = sr_r[1];
  assign taps[2] = sr_r[2];
  assign taps[3] = sr_r[WIDTH];
  assign taps[4] = sr_r[WIDTH+1];
  assign taps[5] = sr_r[WIDTH+2];
  assign taps[6] = sr_r[2*WIDTH];
  assign taps[7] = sr_r[2*WIDTH+1];
  assign taps[8] = sr_r[2*WIDTH+2];

endmodule

// File: rtl/gaussian_blur.sv
// Streaming 3x3 Gaussian smoothing between FWFT grayscale FIFO and Sobel FIFO.
// Define GAUSSIAN_ROUND_EN for round-half-up; default build truncates.
module gaussian_blur
  import gaussian_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int N_W   = $clog2(NPIX + 1);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam int SUM_W = DATA_WIDTH + 4;

  localparam logic [N_W-1:0]   N_FILL_LAST = N_W'(WIDTH + 1);
  localparam logic [N_W-1:0]   N_RUN_LAST  = N_W'(NPIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(WIDTH - 1);
`ifdef GAUSSIAN_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_ADD   = SUM_W'(ROUND_CONST);
`else
  localparam logic [SUM_W-1:0] ROUND_ADD   = SUM_W'(0);
`endif

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [N_W-1:0]              n_in_r;
  logic [ROW_W-1:0]            out_row_r;
  logic [COL_W-1:0]            out_col_r;
  logic [8:0][DATA_WIDTH-1:0]  taps_s;
  logic                        shift_en_s;
  logic [DATA_WIDTH-1:0]       shift_din_s;
  logic                        fire_s;
  logic                        last_pix_s;
  logic                        border_s;
  logic [SUM_W-1:0]            sum_s;
  logic [DATA_WIDTH-1:0]       blur_s;

  gaussian_window #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en_s),
    .din      (shift_din_s),
    .taps     (taps_s)
  );

  assign fire_s     = !in_empty && !out_full;
  assign last_pix_s = (out_row_r == ROW_LAST) && (out_col_r == COL_LAST);

  // Handshakes are held low while reset is asserted so no pixel is lost.
  always_comb begin
    state_nxt_s = state_r;
    in_rd_en    = 1'b0;
    out_wr_en   = 1'b0;
    shift_en_s  = 1'b0;
    shift_din_s = in_dout;
    if (reset) begin
      state_nxt_s = S_FILL;
    end else begin
      case (state_r)
        S_FILL: begin
          in_rd_en   = !in_empty;
          shift_en_s = !in_empty;
          if (!in_empty && (n_in_r == N_FILL_LAST)) state_nxt_s = S_RUN;
          else                                      state_nxt_s = S_FILL;
        end
        S_RUN: begin
          in_rd_en   = fire_s;
          out_wr_en  = fire_s;
          shift_en_s = fire_s;
          if (fire_s && (n_in_r == N_RUN_LAST)) state_nxt_s = S_FLUSH;
          else                                  state_nxt_s = S_RUN;
        end
        S_FLUSH: begin
          out_wr_en   = !out_full;
          shift_en_s  = !out_full;
          shift_din_s = '0;
          if (!out_full && last_pix_s) state_nxt_s = S_FILL;
          else                         state_nxt_s = S_FLUSH;
        end
        default: begin
          state_nxt_s = S_FILL;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= S_FILL;
    else       state_r <= state_nxt_s;
  end

  // Input count and raster position of the next output; cleared after the last pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      n_in_r    <= '0;
      out_row_r <= '0;
      out_col_r <= '0;
    end else if (out_wr_en && last_pix_s) begin
      n_in_r    <= '0;
      out_row_r <= '0;
      out_col_r <= '0;
    end else begin
      if (in_rd_en) n_in_r <= n_in_r + N_W'(1);
      if (out_wr_en) begin
        if (out_col_r == COL_LAST) begin
          out_col_r <= '0;
          out_row_r <= out_row_r + ROW_W'(1);
        end else begin
          out_col_r <= out_col_r + COL_W'(1);
        end
      end
    end
  end

  // Weighted sum fits SUM_W bits even with the rounding term added.
  assign sum_s = SUM_W'(K_CORNER) * (SUM_W'(taps_s[0]) + SUM_W'(taps_s[2]) +
                                     SUM_W'(taps_s[6]) + SUM_W'(taps_s[8]))
               + SUM_W'(K_EDGE)   * (SUM_W'(taps_s[1]) + SUM_W'(taps_s[3]) +
                                     SUM_W'(taps_s[5]) + SUM_W'(taps_s[7]))
               + SUM_W'(K_CENTRE) *  SUM_W'(taps_s[4])
               + ROUND_ADD;

  assign blur_s   = DATA_WIDTH'(sum_s >> SUM_SHIFT);
  assign border_s = (out_row_r == '0) || (out_row_r == ROW_LAST) ||
                    (out_col_r == '0) || (out_col_r == COL_LAST);
  assign out_din  = border_s ? '0 : blur_s;

endmodule
